// File: rtl/ps2_tx.sv
// ps2_tx: host-to-device PS/2 transmitter.
// Runs request-to-send, shifts out 8 data bits + odd parity on device clock
// falling edges, releases the data line for the stop bit, samples the device
// acknowledge and waits for the device to release both lines. A watchdog
// aborts any transfer that stalls after request-to-send.
module ps2_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_ps2,
  input  logic [7:0] din,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic       tx_idle,
  output logic       tx_done_tick,
  output logic       ack_err
);

  localparam int RW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RTS,
    S_START,
    S_DATA_END,
    S_STOP,
    S_WAIT_REL
  } state_t;

  state_t        state;
  logic [7:0]    filt;
  logic          fclk;
  logic          fall_edge;
  logic          ps2d_meta;
  logic          ps2d_s;
  logic [8:0]    shreg;
  logic [3:0]    n;
  logic [RW-1:0] rts_cnt;
  logic [TW-1:0] tmo_cnt;

  // Clock-line glitch filter and falling-edge detector. While we hold the
  // clock low ourselves the filter is parked at "high" so our own inhibit
  // pulse never looks like a device edge.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking (<=) so every register in this
    // block samples the pre-edge values, independent of statement order.
    if (!reset) begin
      filt      <= 8'hFF;
      fclk      <= 1'b1;
      fall_edge <= 1'b0;
    end else if (ps2c_oe) begin
      filt      <= 8'hFF;
      fclk      <= 1'b1;
      fall_edge <= 1'b0;
    end else begin
      filt      <= {ps2c_in, filt[7:1]};
      fall_edge <= fclk && (filt == 8'h00);
      if (filt == 8'hFF)
        fclk <= 1'b1;
      else if (filt == 8'h00)
        fclk <= 1'b0;
    end
  end

  // Two-flop synchronizer for the asynchronous data pad.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ps2d_meta <= 1'b1;
      ps2d_s    <= 1'b1;
    end else begin
      ps2d_meta <= ps2d_in;
      ps2d_s    <= ps2d_meta;
    end
  end

  // Transfer FSM with registered line drivers and status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      shreg        <= '0;
      n            <= '0;
      rts_cnt      <= '0;
      tmo_cnt      <= '0;
      ps2c_oe      <= 1'b0;
      ps2d_oe      <= 1'b0;
      tx_idle      <= 1'b1;
      tx_done_tick <= 1'b0;
      ack_err      <= 1'b0;
    end else begin
      tx_done_tick <= 1'b0;
      case (state)
        S_IDLE: begin
          if (wr_ps2) begin
            shreg   <= {~^din, din};
            n       <= '0;
            rts_cnt <= '0;
            tmo_cnt <= '0;
            ps2c_oe <= 1'b1;
            tx_idle <= 1'b0;
            state   <= S_RTS;
          end else begin
            tx_idle <= 1'b1;
          end
        end

        S_RTS: begin
          rts_cnt <= rts_cnt + 1'b1;
          // Start bit goes low one cycle before the clock is let go.
          if (rts_cnt == RW'(INHIBIT_CYCLES - 2))
            ps2d_oe <= 1'b1;
          if (rts_cnt == RW'(INHIBIT_CYCLES - 1)) begin
            ps2c_oe <= 1'b0;
            tmo_cnt <= '0;
            state   <= S_START;
          end
        end

        default: begin
          if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            ps2c_oe      <= 1'b0;
            ps2d_oe      <= 1'b0;
            ack_err      <= 1'b1;
            tx_done_tick <= 1'b1;
            state        <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
            case (state)
              S_START: begin
                if (fall_edge) begin
                  ps2d_oe <= ~shreg[0];
                  shreg   <= {1'b0, shreg[8:1]};
                  n       <= n + 1'b1;
                  if (n == 4'd8)
                    state <= S_DATA_END;
                end
              end
              S_DATA_END: begin
                if (fall_edge) begin
                  ps2d_oe <= 1'b0;
                  state   <= S_STOP;
                end
              end
              S_STOP: begin
                if (fall_edge) begin
                  ack_err <= ps2d_s;
                  state   <= S_WAIT_REL;
                end
              end
              S_WAIT_REL: begin
                if (fclk && ps2d_s) begin
                  tx_done_tick <= 1'b1;
                  state        <= S_IDLE;
                end
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

endmodule
